// File: rtl/jt12_timers.sv
// jt12_timers: YM2612-style Timer A / Timer B with overflow flags and IRQ.
// Timer A is a 10-bit up-counter stepping once per tick; Timer B is an 8-bit
// up-counter stepping once per 2^TB_PRES_W ticks. A tick is clk_en & zero.
module jt12_timers #(
  parameter int unsigned TB_PRES_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_en,
  input  logic       zero,
  input  logic [9:0] value_A,
  input  logic [7:0] value_B,
  input  logic       load_A,
  input  logic       load_B,
  input  logic       enable_irq_A,
  input  logic       enable_irq_B,
  input  logic       clr_flag_A,
  input  logic       clr_flag_B,
  output logic       flag_A,
  output logic       flag_B,
  output logic       overflow_A,
  output logic       irq_n
);

  localparam logic [TB_PRES_W-1:0] PRES_ONE = TB_PRES_W'(1);

  logic                 tick;

  logic [9:0]           cnt_A_q, cnt_A_d;
  logic                 last_A_q, last_A_d;
  logic                 ovf_A_q, ovf_A_d;
  logic                 flag_A_q, flag_A_d;
  logic                 set_A;

  logic [7:0]           cnt_B_q, cnt_B_d;
  logic [TB_PRES_W-1:0] pres_B_q, pres_B_d;
  logic                 last_B_q, last_B_d;
  logic                 flag_B_q, flag_B_d;
  logic                 set_B;

  assign tick = clk_en & zero;

  // Timer A: load on rising load_A, count while held, reload and pulse at 1023.
  always_comb begin
    cnt_A_d  = cnt_A_q;
    last_A_d = last_A_q;
    ovf_A_d  = 1'b0;
    set_A    = 1'b0;
    if (tick) begin
      last_A_d = load_A;
      if (load_A) begin
        if (!last_A_q) begin
          cnt_A_d = value_A;
        end else if (cnt_A_q == '1) begin
          cnt_A_d = value_A;
          ovf_A_d = 1'b1;
          set_A   = enable_irq_A;
        end else begin
          cnt_A_d = cnt_A_q + 10'd1;
        end
      end
    end
  end

  // Timer B: prescaled counter; the counter steps on the tick where the
  // prescaler is all-ones (it wraps to zero on that same tick).
  always_comb begin
    cnt_B_d  = cnt_B_q;
    pres_B_d = pres_B_q;
    last_B_d = last_B_q;
    set_B    = 1'b0;
    if (tick) begin
      last_B_d = load_B;
      if (load_B) begin
        if (!last_B_q) begin
          cnt_B_d  = value_B;
          pres_B_d = '0;
        end else begin
          pres_B_d = pres_B_q + PRES_ONE;
          if (pres_B_q == '1) begin
            if (cnt_B_q == '1) begin
              cnt_B_d = value_B;
              set_B   = enable_irq_B;
            end else begin
              cnt_B_d = cnt_B_q + 8'd1;
            end
          end
        end
      end
    end
  end

  // Flags: clear strobe wins over a simultaneous set; otherwise sticky.
  always_comb begin
    flag_A_d = flag_A_q;
    flag_B_d = flag_B_q;
    if (clr_flag_A)  flag_A_d = 1'b0;
    else if (set_A)  flag_A_d = 1'b1;
    if (clr_flag_B)  flag_B_d = 1'b0;
    else if (set_B)  flag_B_d = 1'b1;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_A_q  <= '0;
      last_A_q <= 1'b0;
      ovf_A_q  <= 1'b0;
      flag_A_q <= 1'b0;
      cnt_B_q  <= '0;
      pres_B_q <= '0;
      last_B_q <= 1'b0;
      flag_B_q <= 1'b0;
    end else begin
      cnt_A_q  <= cnt_A_d;
      last_A_q <= last_A_d;
      ovf_A_q  <= ovf_A_d;
      flag_A_q <= flag_A_d;
      cnt_B_q  <= cnt_B_d;
      pres_B_q <= pres_B_d;
      last_B_q <= last_B_d;
      flag_B_q <= flag_B_d;
    end
  end

  assign flag_A     = flag_A_q;
  assign flag_B     = flag_B_q;
  assign overflow_A = ovf_A_q;
  assign irq_n      = ~(flag_A_q | flag_B_q);

endmodule
